// File: rtl/alu_pipe.sv
// Pipelined accumulator ALU: single-cycle logic/arithmetic ops plus an optional
// shift-add multiplier (opcode 8) that exists only when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_ena,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] accum,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             carry,
   output logic             busy,
   output logic             done,
   output logic             illegal
);

   localparam logic [3:0] OP_HLT  = 4'd0;
   localparam logic [3:0] OP_SKZ  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_ANDD = 4'd3;
   localparam logic [3:0] OP_XORR = 4'd4;
   localparam logic [3:0] OP_LDA  = 4'd5;
   localparam logic [3:0] OP_STO  = 4'd6;
   localparam logic [3:0] OP_JMP  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;

   logic [WIDTH-1:0] alu_out_q;
   logic             carry_q;
   logic             done_q;
   logic             illegal_q;

   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] res_d;
   logic             carry_d;
   logic             legal_d;
   logic             is_mul_d;

`ifdef ALU_PIPE_MUL_EN
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_e;

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] prod_step_s;

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   assign prod_step_s = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   assign busy        = (state_q == S_MUL);
`else
   assign busy        = 1'b0;
`endif

   assign zero    = (accum == {WIDTH{1'b0}});
   assign alu_out = alu_out_q;
   assign carry   = carry_q;
   assign done    = done_q;
   assign illegal = illegal_q;

   // Decode the presented opcode into the single-cycle result it would produce.
   always_comb begin
      sum_s    = {1'b0, data} + {1'b0, accum};
      res_d    = alu_out_q;
      carry_d  = carry_q;
      legal_d  = 1'b1;
      is_mul_d = 1'b0;
      case (opcode)
         OP_HLT, OP_SKZ, OP_STO, OP_JMP: res_d = accum;
         OP_ADD: begin
            res_d   = sum_s[WIDTH-1:0];
            carry_d = sum_s[WIDTH];
         end
         OP_ANDD: res_d = data & accum;
         OP_XORR: res_d = data ^ accum;
         OP_LDA:  res_d = data;
`ifdef ALU_PIPE_MUL_EN
         OP_MUL:  is_mul_d = 1'b1;
`endif
         default: legal_d = 1'b0;
      endcase
   end

   // Request acceptance, result/flag registers and the multiplier sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_q <= {WIDTH{1'b0}};
         carry_q   <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         mcand_q   <= {(2*WIDTH){1'b0}};
         mplier_q  <= {WIDTH{1'b0}};
         prod_q    <= {(2*WIDTH){1'b0}};
`endif
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         if (state_q == S_MUL) begin
            prod_q   <= prod_step_s;
            mcand_q  <= mcand_q << 1'b1;
            mplier_q <= mplier_q >> 1'b1;
            cnt_q    <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_q   <= S_IDLE;
               alu_out_q <= prod_step_s[WIDTH-1:0];
               carry_q   <= |prod_step_s[2*WIDTH-1:WIDTH];
               done_q    <= 1'b1;
            end
         end else if (alu_ena && is_mul_d) begin
            // Operands are captured here so later input changes cannot disturb the product.
            state_q  <= S_MUL;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {{WIDTH{1'b0}}, data};
            mplier_q <= accum;
            prod_q   <= {(2*WIDTH){1'b0}};
         end else
`endif
         if (alu_ena) begin
            alu_out_q <= res_d;
            carry_q   <= carry_d;
            done_q    <= 1'b1;
            illegal_q <= ~legal_d;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors plus random traffic against an arithmetic model.
module tb_alu_pipe;

   localparam int W = 8;

   logic          clk;
   logic          rst_n;
   logic          alu_ena;
   logic [3:0]    opcode;
   logic [W-1:0]  data;
   logic [W-1:0]  accum;
   logic [W-1:0]  alu_out;
   logic          zero;
   logic          carry;
   logic          busy;
   logic          done;
   logic          illegal;

   alu_pipe #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .alu_ena (alu_ena),
      .opcode  (opcode),
      .data    (data),
      .accum   (accum),
      .alu_out (alu_out),
      .zero    (zero),
      .carry   (carry),
      .busy    (busy),
      .done    (done),
      .illegal (illegal)
   );

   typedef struct {
      logic [W-1:0] out;
      logic         cry;
      logic         ill;
      int           cyc;
   } exp_t;

   exp_t          sb_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            mul_left = 0;
   logic [W-1:0]  model_out = '0;
   logic          model_cry = 1'b0;

`ifdef ALU_PIPE_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_done: got done=1 alu_out=%h at cycle %0d, expected no completion", alu_out, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (alu_out !== e.out || carry !== e.cry || illegal !== e.ill || cyc != e.cyc) begin
               errors++;
               $display("FAIL result: got out=%h carry=%b illegal=%b cycle=%0d, expected out=%h carry=%b illegal=%b cycle=%0d",
                        alu_out, carry, illegal, cyc, e.out, e.cry, e.ill, e.cyc);
            end
         end
      end else if (rst_n && illegal) begin
         checks++;
         errors++;
         $display("FAIL illegal_without_done: got illegal=1 done=0, expected illegal only with done");
      end
   end

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: result of an accepted request computed with plain arithmetic.
   task automatic model_issue(input logic [3:0] op, input logic [W-1:0] d, input logic [W-1:0] a);
      exp_t          e;
      longint unsigned s;
      longint unsigned modv;
      modv  = longint'(1) << W;
      e.ill = 1'b0;
      e.cyc = cyc + 1;
      if (op == 4'd0 || op == 4'd1 || op == 4'd6 || op == 4'd7) model_out = a;
      else if (op == 4'd2) begin
         s = longint'(d) + longint'(a);
         model_out = W'(s % modv);
         model_cry = (s / modv) != 0;
      end
      else if (op == 4'd3) model_out = d & a;
      else if (op == 4'd4) model_out = d ^ a;
      else if (op == 4'd5) model_out = d;
      else if (op == 4'd8 && MUL_ON) begin
         s = longint'(d) * longint'(a);
         model_out = W'(s % modv);
         model_cry = (s / modv) != 0;
         e.cyc     = cyc + 1 + W;
         mul_left  = W;
      end
      else e.ill = 1'b1;
      e.out = model_out;
      e.cry = model_cry;
      sb_q.push_back(e);
   endtask

   // One clock of stimulus, applied on the falling edge.
   task automatic step(input bit ena, input logic [3:0] op, input logic [W-1:0] d, input logic [W-1:0] a);
      @(negedge clk);
      check("busy", busy, mul_left > 0);
      alu_ena = ena;
      opcode  = op;
      data    = d;
      accum   = a;
      #1;
      check("zero", zero, a == 0);
      if (mul_left > 0) mul_left--;
      else if (ena) model_issue(op, d, a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      alu_ena = 1'b1;
      opcode  = 4'd5;
      data    = 8'h77;
      #1;
      check("rst_alu_out", alu_out, 0);
      check("rst_carry", carry, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_illegal", illegal, 0);
      sb_q.delete();
      mul_left  = 0;
      model_out = '0;
      model_cry = 1'b0;
      @(negedge clk);
      @(negedge clk);
      alu_ena = 1'b0;
      rst_n   = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      alu_ena = 1'b0;
      opcode  = 4'd0;
      data    = '0;
      accum   = '0;
      do_reset();

      step(1'b1, 4'd2, 8'hF0, 8'h20);
      step(1'b0, 4'd0, 8'h00, 8'h20);
      step(1'b1, 4'd3, 8'hCC, 8'h0F);
      step(1'b1, 4'd4, 8'hFF, 8'h0F);
      step(1'b0, 4'd0, 8'h00, 8'h0F);
      step(1'b1, 4'd5, 8'h3C, 8'h01);
      step(1'b1, 4'hB, 8'h11, 8'h22);
      step(1'b1, 4'd8, 8'h11, 8'h22);
      for (int i = 0; i < W + 2; i++) step(1'b0, 4'd0, 8'h00, 8'h05);

      if (MUL_ON) begin
         step(1'b1, 4'd8, 8'h10, 8'h11);
         for (int i = 0; i < W; i++) step(1'b1, 4'd5, 8'(i), 8'(255 - i));
         step(1'b0, 4'd0, 8'h00, 8'h00);
         step(1'b1, 4'd8, 8'h05, 8'h03);
         for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 8'h00, 8'h00);
         do_reset();
         step(1'b1, 4'd5, 8'hA5, 8'h00);
         step(1'b0, 4'd0, 8'h00, 8'h00);
      end

      // zero must track accum alone, regardless of reset or enable.
      @(negedge clk);
      alu_ena = 1'b0;
      accum   = 8'h00;
      #1 check("zero_acc0", zero, 1);
      rst_n = 1'b0;
      #1 check("zero_in_rst", zero, 1);
      rst_n = 1'b1;
      #1 check("zero_after_rst", zero, 1);
      accum = 8'h01;
      #1 check("zero_acc1", zero, 0);
      sb_q.delete();
      mul_left  = 0;
      model_out = '0;
      model_cry = 1'b0;

      for (int i = 0; i < 400; i++) begin
         logic [3:0]   op;
         logic [W-1:0] a;
         op = ($urandom_range(0, 5) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
         a  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 149) == 0) do_reset();
         else step($urandom_range(0, 3) != 0, op, 8'($urandom), a);
      end

      for (int i = 0; i < W + 3; i++) step(1'b0, 4'd0, 8'h00, 8'h00);
      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
